round_ctl: RTL and testbench

- Game-round controller sitting directly upstream of the time-bar overlay.
- Drives the time bar's module_en, start, bonus and one_ms_tick inputs, and consumes its elapsed flag.
- Generates the millisecond tick, sequences one round (ready -> run -> over), counts landings as score, and rate-limits bonus requests.
- Feeds score and game_over to the HUD/menu logic.

---
 rtl/round_ctl_if.sv | 27 ++
 rtl/round_ctl.sv | 127 ++++++++++++
 tb/tb_round_ctl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/round_ctl_if.sv
// Signal bundle between the round controller, its input sources and the time bar / HUD.
// The controller binds to the slave modport; the driving side uses master.
interface round_ctl_if #(
    parameter int unsigned SCORE_WIDTH = 14
);
    logic                   game_en;
    logic                   btn_start;
    logic                   land;
    logic                   fall;
    logic                   elapsed;
    logic                   module_en;
    logic                   start;
    logic                   bonus;
    logic                   one_ms_tick;
    logic                   game_over;
    logic [SCORE_WIDTH-1:0] score;

    modport master (
        output game_en, btn_start, land, fall, elapsed,
        input  module_en, start, bonus, one_ms_tick, game_over, score
    );

    modport slave (
        input  game_en, btn_start, land, fall, elapsed,
        output module_en, start, bonus, one_ms_tick, game_over, score
    );
endinterface

// File: rtl/round_ctl.sv
// Game-round controller: millisecond prescaler, ready/run/over sequencing,
// landing score with saturation, and bonus requests rate-limited by a ms cooldown.
module round_ctl #(
    parameter int unsigned TICKS_PER_MS      = 65000,
    parameter int unsigned BONUS_COOLDOWN_MS = 500,
    parameter int unsigned SCORE_WIDTH       = 14
) (
    input logic        clk,
    input logic        rst,
    round_ctl_if.slave bus
);
    localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int unsigned CW = (BONUS_COOLDOWN_MS > 0) ? $clog2(BONUS_COOLDOWN_MS + 1) : 1;
    localparam logic [PW-1:0]          PRESC_MAX = PW'(TICKS_PER_MS - 1);
    localparam logic [CW-1:0]          COOL_LOAD = CW'(BONUS_COOLDOWN_MS);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_OVER} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PW-1:0]          presc;
    logic                   tick_q;
    logic                   btn_start_q;
    logic                   btn_press;
    logic [CW-1:0]          cooldown;
    logic [CW-1:0]          cooldown_next;
    logic [SCORE_WIDTH-1:0] score_q;
    logic [SCORE_WIDTH-1:0] score_next;
    logic                   start_d;
    logic                   bonus_d;
    logic                   module_en_q;
    logic                   start_q;
    logic                   bonus_q;
    logic                   game_over_q;

    assign btn_press = bus.btn_start & ~btn_start_q;

    // Free-running prescaler, independent of the round state
    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            tick_q      <= 1'b0;
            btn_start_q <= 1'b0;
        end else begin
            tick_q      <= (presc == PRESC_MAX);
            presc       <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
            btn_start_q <= bus.btn_start;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            score_q     <= '0;
            cooldown    <= '0;
            module_en_q <= 1'b0;
            start_q     <= 1'b0;
            bonus_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state       <= state_next;
            score_q     <= score_next;
            cooldown    <= cooldown_next;
            module_en_q <= (state_next != S_IDLE);
            start_q     <= start_d;
            bonus_q     <= bonus_d;
            game_over_q <= (state_next == S_OVER);
        end
    end

    // Losing game_en overrides every other transition
    always_comb begin
        state_next = state;
        if (!bus.game_en) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_next = S_READY;
                S_READY: if (btn_press) state_next = S_RUN;
                S_RUN:   if (bus.fall || bus.elapsed) state_next = S_OVER;
                S_OVER:  if (btn_press) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        start_d       = 1'b0;
        bonus_d       = 1'b0;
        score_next    = score_q;
        cooldown_next = cooldown;
        if (bus.game_en) begin
            case (state)
                S_READY: begin
                    if (btn_press) begin
                        start_d       = 1'b1;
                        score_next    = '0;
                        cooldown_next = '0;
                    end
                end
                S_RUN: begin
                    if (!(bus.fall || bus.elapsed)) begin
                        if (bus.land) begin
                            if (score_q != SCORE_MAX) score_next = score_q + 1'b1;
                            if (cooldown == '0) begin
                                bonus_d       = 1'b1;
                                cooldown_next = COOL_LOAD;
                            end
                        end
                        // A fresh load wins over a coincident tick
                        if (!bonus_d && tick_q && cooldown != '0)
                            cooldown_next = cooldown - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.module_en   = module_en_q;
    assign bus.start       = start_q;
    assign bus.bonus       = bonus_q;
    assign bus.one_ms_tick = tick_q;
    assign bus.game_over   = game_over_q;
    assign bus.score       = score_q;
endmodule

// File: tb/tb_round_ctl.sv
// Self-checking bench for round_ctl: per-cycle comparison against a round-level
// model plus directed scenarios with hand-computed expectations.
module tb_round_ctl;
    localparam int T = 10;
    localparam int C = 3;
    localparam int W = 14;
    localparam int SMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    round_ctl_if #(.SCORE_WIDTH(W)) bus();

    round_ctl #(
        .TICKS_PER_MS(T),
        .BONUS_COOLDOWN_MS(C),
        .SCORE_WIDTH(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round-level model: phase, score, and ms elapsed in play since the last bonus
    typedef enum {PH_OFF, PH_ARMED, PH_PLAY, PH_DONE} phase_t;
    phase_t ph = PH_OFF;
    int  cyc = 0;
    int  m_score = 0;
    int  since = 0;
    bit  bonus_seen = 0;
    bit  btn_prev = 0;
    bit  exp_tick = 0, exp_start = 0, exp_bonus = 0;
    bit  press, cur_tick;

    always @(posedge clk) begin
        if (rst) begin
            ph = PH_OFF; cyc = 0; m_score = 0; since = 0; bonus_seen = 0;
            btn_prev = 0; exp_tick = 0; exp_start = 0; exp_bonus = 0;
        end else begin
            press = bus.btn_start && !btn_prev;
            btn_prev = bus.btn_start;
            cur_tick = exp_tick;
            cyc++;
            exp_tick = (cyc % T) == 0;
            exp_start = 0;
            exp_bonus = 0;
            if (!bus.game_en) begin
                ph = PH_OFF;
            end else begin
                case (ph)
                    PH_OFF:   ph = PH_ARMED;
                    PH_ARMED: if (press) begin
                        ph = PH_PLAY; exp_start = 1; m_score = 0; bonus_seen = 0; since = 0;
                    end
                    PH_PLAY: begin
                        if (bus.fall || bus.elapsed) begin
                            ph = PH_DONE;
                        end else begin
                            if (bus.land) begin
                                if (m_score < SMAX) m_score++;
                                if (!bonus_seen || since >= C) begin
                                    exp_bonus = 1; bonus_seen = 1; since = -1;
                                end
                            end
                            if (cur_tick && since >= 0) since++;
                            if (since < 0) since = 0;
                        end
                    end
                    PH_DONE:  if (press) ph = PH_OFF;
                    default:  ph = PH_OFF;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_module_en", bus.module_en, (ph != PH_OFF));
            check("cmp_game_over", bus.game_over, (ph == PH_DONE));
            check("cmp_start", bus.start, exp_start);
            check("cmp_bonus", bus.bonus, exp_bonus);
            check("cmp_tick", bus.one_ms_tick, exp_tick);
            check("cmp_score", bus.score, m_score);
        end
    end

    int ticks, first_tick, starts;

    initial begin
        bus.game_en = 0; bus.btn_start = 0; bus.land = 0; bus.fall = 0; bus.elapsed = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("rst_module_en", bus.module_en, 0);
        check("rst_score", bus.score, 0);
        check("rst_tick", bus.one_ms_tick, 0);
        rst = 0;

        // Idle: ticks at 10, 20, 30 cycles after release
        ticks = 0; first_tick = 0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            check("idle_tick", bus.one_ms_tick, (k % 10) == 0);
            if (bus.one_ms_tick) begin
                ticks++;
                if (first_tick == 0) first_tick = k;
            end
        end
        check("tick_count", ticks, 3);
        check("first_tick", first_tick, 10);

        bus.game_en = 1;
        @(negedge clk);
        check("ready_module_en", bus.module_en, 1);
        bus.btn_start = 1;
        starts = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            starts += bus.start;
        end
        check("start_count", starts, 1);
        check("start_score", bus.score, 0);
        bus.btn_start = 0;
        @(negedge clk);

        // Lands 0, 2 ms and 4 ms apart: bonus on first and third only
        bus.land = 1; @(negedge clk); bus.land = 0;
        check("bonus_land1", bus.bonus, 1);
        repeat (19) @(negedge clk);
        bus.land = 1; @(negedge clk); bus.land = 0;
        check("bonus_land2", bus.bonus, 0);
        repeat (19) @(negedge clk);
        bus.land = 1; @(negedge clk); bus.land = 0;
        check("bonus_land3", bus.bonus, 1);
        check("score_3", bus.score, 3);

        bus.land = 1; bus.fall = 1; @(negedge clk); bus.land = 0; bus.fall = 0;
        check("fall_score", bus.score, 3);
        check("fall_bonus", bus.bonus, 0);
        check("fall_game_over", bus.game_over, 1);
        check("fall_module_en", bus.module_en, 1);

        bus.btn_start = 1; @(negedge clk); bus.btn_start = 0;
        check("over_exit_module_en", bus.module_en, 0);
        check("over_exit_game_over", bus.game_over, 0);
        @(negedge clk);
        check("rearm_module_en", bus.module_en, 1);
        check("rearm_score_held", bus.score, 3);

        bus.btn_start = 1; @(negedge clk); bus.btn_start = 0;
        check("round2_start", bus.start, 1);
        check("round2_score", bus.score, 0);
        bus.land = 1; @(negedge clk); bus.land = 0;
        check("round2_bonus", bus.bonus, 1);
        bus.elapsed = 1; @(negedge clk); bus.elapsed = 0;
        check("elapsed_game_over", bus.game_over, 1);
        bus.btn_start = 1; @(negedge clk); bus.btn_start = 0;
        check("elapsed_exit_module_en", bus.module_en, 0);
        @(negedge clk);
        check("elapsed_ready_module_en", bus.module_en, 1);
        check("elapsed_ready_game_over", bus.game_over, 0);
        check("elapsed_score_held", bus.score, 1);

        // Saturation: land every cycle until the counter tops out
        bus.btn_start = 1; @(negedge clk); bus.btn_start = 0;
        check("round3_start", bus.start, 1);
        bus.land = 1;
        repeat (SMAX) @(negedge clk);
        check("score_max", bus.score, 16383);
        @(negedge clk);
        check("score_saturated", bus.score, 16383);

        rst = 1; @(negedge clk);
        check("midrst_module_en", bus.module_en, 0);
        check("midrst_score", bus.score, 0);
        check("midrst_bonus", bus.bonus, 0);
        check("midrst_game_over", bus.game_over, 0);
        rst = 0; bus.land = 0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
